// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and
// data requesters; data has priority, bounded by an anti-starvation counter for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_rsp_valid,
  input  logic [DATA_W-1:0]     m_rsp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWNER_D  = 1'b0;
  localparam logic OWNER_IF = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic              owner_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [DATA_W-1:0] wdata_r;

  logic              grant_d_s;
  logic              grant_if_s;
  logic              fetch_starved_s;

  assign fetch_starved_s = if_req_valid && (starve_cnt_r == CNT_LIMIT);

  // Combinational grant in IDLE: data wins unless fetch has hit the starvation limit.
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    if (!rst && (state_r == ST_IDLE)) begin
      if (d_req_valid && !fetch_starved_s) begin
        grant_d_s = 1'b1;
      end else if (if_req_valid) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s || grant_if_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_req_ready) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (m_rsp_valid) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, owner and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWNER_D;
      starve_cnt_r <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      if (grant_if_s) begin
        owner_r      <= OWNER_IF;
        starve_cnt_r <= CNT_ZERO;
      end else if (grant_d_s) begin
        owner_r <= OWNER_D;
        if (if_req_valid && (starve_cnt_r != CNT_LIMIT)) begin
          starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Request fields are captured on the accept cycle; fetches are always reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      wstrb_r <= {STRB_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (grant_d_s) begin
      addr_r  <= d_addr;
      we_r    <= d_we;
      wstrb_r <= d_wstrb;
      wdata_r <= d_wdata;
    end else if (grant_if_s) begin
      addr_r  <= if_addr;
      we_r    <= 1'b0;
      wstrb_r <= {STRB_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end
  end

  assign if_req_ready = grant_if_s;
  assign d_req_ready  = grant_d_s;

  assign m_req_valid = !rst && (state_r == ST_ISSUE);
  assign m_addr      = rst ? {ADDR_W{1'b0}} : addr_r;
  assign m_we        = rst ? 1'b0 : we_r;
  assign m_wstrb     = rst ? {STRB_W{1'b0}} : wstrb_r;
  assign m_wdata     = rst ? {DATA_W{1'b0}} : wdata_r;

  // Responses outside WAIT are stale or spurious and are never forwarded.
  assign if_rsp_valid = !rst && (state_r == ST_WAIT) && m_rsp_valid && (owner_r == OWNER_IF);
  assign d_rsp_valid  = !rst && (state_r == ST_WAIT) && m_rsp_valid && (owner_r == OWNER_D);
  assign if_rsp_data  = m_rsp_data;
  assign d_rsp_data   = m_rsp_data;

endmodule
